// File: rtl/masked_xor_seq_if.sv
// Operand/randomness/result handshake bundle for the masked XOR sequencer.
interface masked_xor_seq_if #(
  parameter int WIDTH   = 1,
  parameter int STALL_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b0;
  logic [WIDTH-1:0]   b1;
  logic               rnd_valid;
  logic               rnd_ready;
  logic [3*WIDTH-1:0] rnd;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   xor0;
  logic [WIDTH-1:0]   xor1;
  logic               busy;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output in_valid, a0, a1, b0, b1, rnd_valid, rnd, out_ready,
    input  in_ready, rnd_ready, out_valid, xor0, xor1, busy, stall_cnt
  );

  modport slave (
    input  in_valid, a0, a1, b0, b1, rnd_valid, rnd, out_ready,
    output in_ready, rnd_ready, out_valid, xor0, xor1, busy, stall_cnt
  );
endinterface

// File: rtl/masked_xor_seq.sv
// 2-share masked XOR (A&~B ^ ~A&B ^ T) with both product layers registered; result 3 cycles after accept.
// Operands and randomness are taken together only; OUT holds until out_ready, then all share state is zeroed.
module masked_xor_seq #(
  parameter int WIDTH   = 1,
  parameter int STALL_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  masked_xor_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LD, S1, OUT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a0_q, a1_q, b0_q, b1_q;
  logic [3*WIDTH-1:0] rnd_q;
  logic [WIDTH-1:0]   ab0, ab1, an0, an1;
  logic [WIDTH-1:0]   xor0_q, xor1_q;
  logic               out_valid_q;
  logic [STALL_W-1:0] stall_q;

  logic [WIDTH-1:0]   r0, r1, r2;
  logic [WIDTH-1:0]   l1_ab0, l1_ab1, l1_an0, l1_an1;
  logic [WIDTH-1:0]   t0, t1;
  logic               accept;

  assign r0 = rnd_q[WIDTH-1:0];
  assign r1 = rnd_q[2*WIDTH-1:WIDTH];
  assign r2 = rnd_q[3*WIDTH-1:2*WIDTH];

  // Layer 1 only sees input registers; layer 2 only sees layer-1 registers.
  assign l1_ab0 = (a0_q & ~b0_q) ^ (a0_q & b1_q) ^ r0;
  assign l1_ab1 = (a1_q & b1_q) ^ (a1_q & ~b0_q) ^ r0;
  assign l1_an0 = (~a0_q & b0_q) ^ (~a0_q & b1_q) ^ r1;
  assign l1_an1 = (a1_q & b1_q) ^ (a1_q & b0_q) ^ r1;

  assign t0 = (ab0 & an0) ^ (ab0 & an1) ^ r2;
  assign t1 = (ab1 & an1) ^ (ab1 & an0) ^ r2;

  assign accept        = (state == IDLE) && bus.in_valid && bus.rnd_valid;
  assign bus.in_ready  = (state == IDLE) && bus.rnd_valid;
  assign bus.rnd_ready = (state == IDLE) && bus.in_valid;
  assign bus.out_valid = out_valid_q;
  assign bus.xor0      = xor0_q;
  assign bus.xor1      = xor1_q;
  assign bus.busy      = (state != IDLE);
  assign bus.stall_cnt = stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a0_q        <= '0;
      a1_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      rnd_q       <= '0;
      ab0         <= '0;
      ab1         <= '0;
      an0         <= '0;
      an1         <= '0;
      xor0_q      <= '0;
      xor1_q      <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && !bus.rnd_valid && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
          if (accept) begin
            a0_q  <= bus.a0;
            a1_q  <= bus.a1;
            b0_q  <= bus.b0;
            b1_q  <= bus.b1;
            rnd_q <= bus.rnd;
            state <= LD;
          end
        end
        LD: begin
          ab0   <= l1_ab0;
          ab1   <= l1_ab1;
          an0   <= l1_an0;
          an1   <= l1_an1;
          state <= S1;
        end
        S1: begin
          xor0_q      <= ab0 ^ an0 ^ t0;
          xor1_q      <= ab1 ^ an1 ^ t1;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            a0_q        <= '0;
            a1_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            rnd_q       <= '0;
            ab0         <= '0;
            ab1         <= '0;
            an0         <= '0;
            an1         <= '0;
            xor0_q      <= '0;
            xor1_q      <= '0;
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_masked_xor_seq.sv
// Directed bench for masked_xor_seq: an 8-lane instance for the main flow and a 1-lane,
// 4-bit-counter instance for the single-bit vector and counter saturation.
module tb_masked_xor_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  masked_xor_seq_if #(.WIDTH(8), .STALL_W(16)) bus8 ();
  masked_xor_seq_if #(.WIDTH(1), .STALL_W(4))  bus1 ();

  masked_xor_seq #(.WIDTH(8), .STALL_W(16)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  masked_xor_seq #(.WIDTH(1), .STALL_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [23:0] rnd);
    bus8.a0 = a0; bus8.a1 = a1; bus8.b0 = b0; bus8.b1 = b1; bus8.rnd = rnd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.xor0 !== 8'h00 || bus8.xor1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b busy=%b xor0=%h xor1=%h, need 0 0 00 00",
               bus8.out_valid, bus8.busy, bus8.xor0, bus8.xor1);
    end
    checks++;
    if (bus8.stall_cnt !== 16'd0 || bus8.in_ready !== 1'b0 || bus1.stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_counters: stall8=%0d in_ready=%b stall1=%0d, need 0 0 0",
               bus8.stall_cnt, bus8.in_ready, bus1.stall_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  // Lane 0 is a0=1,a1=0,b0=1,b1=1 with rnd {r2,r1,r0}=101; other lanes all zero.
  task automatic test_basic();
    load8(8'h01, 8'h00, 8'h01, 8'h01, {8'h01, 8'h00, 8'h01});
    bus8.in_valid = 1'b1; bus8.rnd_valid = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.rnd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: in_ready=%b rnd_ready=%b, need 1 1", bus8.in_ready, bus8.rnd_ready);
    end
    tick();
    bus8.in_valid = 1'b0; bus8.rnd_valid = 1'b0;
    checks++;
    if (bus8.busy !== 1'b1 || bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ld: busy=%b out_valid=%b, need 1 0", bus8.busy, bus8.out_valid);
    end
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_s1: out_valid=%b, need 0", bus8.out_valid);
    end
    tick();
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.xor0 !== 8'h01 || bus8.xor1 !== 8'h00) begin
      errors++;
      $display("FAIL basic_result: out_valid=%b xor0=%h xor1=%h, need 1 01 00",
               bus8.out_valid, bus8.xor0, bus8.xor1);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.xor0 !== 8'h00 || bus8.xor1 !== 8'h00) begin
      errors++;
      $display("FAIL basic_zeroize: out_valid=%b busy=%b xor0=%h xor1=%h, need 0 0 00 00",
               bus8.out_valid, bus8.busy, bus8.xor0, bus8.xor1);
    end
  endtask

  task automatic test_stall();
    load8(8'hA5, 8'h3C, 8'h0F, 8'hF0, 24'h123456);   // A=99, B=FF
    bus8.in_valid = 1'b1; bus8.rnd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus8.in_ready !== 1'b0 || bus8.rnd_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall_ready[%0d]: in_ready=%b rnd_ready=%b, need 0 1", i, bus8.in_ready, bus8.rnd_ready);
      end
      tick();
    end
    checks++;
    if (bus8.stall_cnt !== 16'd5 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_count: stall_cnt=%0d busy=%b, need 5 0", bus8.stall_cnt, bus8.busy);
    end
    bus8.rnd_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0; bus8.rnd_valid = 1'b0;
    checks++;
    if (bus8.busy !== 1'b1 || bus8.stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_accept: busy=%b stall_cnt=%0d, need 1 5", bus8.busy, bus8.stall_cnt);
    end
    tick(); tick();
    checks++;
    if (bus8.out_valid !== 1'b1 || (bus8.xor0 ^ bus8.xor1) !== 8'h66) begin
      errors++;
      $display("FAIL stall_result: out_valid=%b xor=%h, need 1 66", bus8.out_valid, bus8.xor0 ^ bus8.xor1);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] x0, x1;
    int bad;
    load8(8'h5A, 8'hC3, 8'h12, 8'h34, 24'hA1B2C3);   // A=99, B=26
    bus8.in_valid = 1'b1; bus8.rnd_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0; bus8.rnd_valid = 1'b0;
    tick(); tick();
    x0 = bus8.xor0; x1 = bus8.xor1;
    checks++;
    if (bus8.out_valid !== 1'b1 || (x0 ^ x1) !== 8'hBF) begin
      errors++;
      $display("FAIL bp_result: out_valid=%b xor=%h, need 1 BF", bus8.out_valid, x0 ^ x1);
    end
    // New operands offered while held must be ignored.
    load8(8'hFF, 8'h00, 8'h00, 8'h00, 24'hFFFFFF);
    bus8.in_valid = 1'b1; bus8.rnd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.out_valid !== 1'b1 || bus8.xor0 !== x0 || bus8.xor1 !== x1 ||
          bus8.in_ready !== 1'b0 || bus8.rnd_ready !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d of 10 held cycles changed, need 0", bad);
    end
    bus8.in_valid = 1'b0; bus8.rnd_valid = 1'b0;
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.xor0 !== 8'h00 || bus8.xor1 !== 8'h00) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b busy=%b xor0=%h xor1=%h, need 0 0 00 00",
               bus8.out_valid, bus8.busy, bus8.xor0, bus8.xor1);
    end
  endtask

  task automatic test_async_reset();
    load8(8'h0F, 8'hF0, 8'h33, 8'h55, 24'h5A5A5A);
    bus8.in_valid = 1'b1; bus8.rnd_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0; bus8.rnd_valid = 1'b0;
    tick();                 // now in S1
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0 || bus8.xor0 !== 8'h00 ||
        bus8.xor1 !== 8'h00 || bus8.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b busy=%b xor0=%h xor1=%h stall=%0d, need 0 0 00 00 0",
               bus8.out_valid, bus8.busy, bus8.xor0, bus8.xor1, bus8.stall_cnt);
    end
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_dropped: out_valid=%b busy=%b, need 0 0", bus8.out_valid, bus8.busy);
    end
    rst = 1'b0;
    tick();
    load8(8'hFF, 8'h00, 8'hF0, 8'h00, 24'h13579B);   // A=FF, B=F0
    bus8.in_valid = 1'b1; bus8.rnd_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0; bus8.rnd_valid = 1'b0;
    tick(); tick();
    checks++;
    if (bus8.out_valid !== 1'b1 || (bus8.xor0 ^ bus8.xor1) !== 8'h0F) begin
      errors++;
      $display("FAIL async_next_op: out_valid=%b xor=%h, need 1 0F", bus8.out_valid, bus8.xor0 ^ bus8.xor1);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] a0, a1, b0, b1, exp;
    for (int n = 0; n < 1000; n++) begin
      a0 = 8'($urandom); a1 = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
      exp = (a0 ^ a1) ^ (b0 ^ b1);
      load8(a0, a1, b0, b1, 24'($urandom));
      bus8.in_valid = 1'b1; bus8.rnd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      bus8.rnd_valid = 1'b1;
      #1;
      checks++;
      if (bus8.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_ready[%0d]: in_ready=%b, need 1", n, bus8.in_ready);
      end
      tick();
      bus8.in_valid = 1'b0; bus8.rnd_valid = 1'b0;
      for (int i = 0; i < 10 && bus8.out_valid !== 1'b1; i++) tick();
      repeat ($urandom_range(0, 2)) tick();
      checks++;
      if (bus8.out_valid !== 1'b1 || (bus8.xor0 ^ bus8.xor1) !== exp) begin
        errors++;
        $display("FAIL rand_op[%0d]: out_valid=%b xor=%h, need 1 %h", n, bus8.out_valid,
                 bus8.xor0 ^ bus8.xor1, exp);
      end
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
    end
  endtask

  task automatic test_width1_saturation();
    bus1.a0 = 1'b1; bus1.a1 = 1'b0; bus1.b0 = 1'b1; bus1.b1 = 1'b1; bus1.rnd = 3'b101;
    bus1.in_valid = 1'b1; bus1.rnd_valid = 1'b0;
    repeat (14) tick();
    checks++;
    if (bus1.stall_cnt !== 4'd14) begin
      errors++;
      $display("FAIL sat_count14: stall_cnt=%0d, need 14", bus1.stall_cnt);
    end
    repeat (6) tick();
    checks++;
    if (bus1.stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold: stall_cnt=%h, need F", bus1.stall_cnt);
    end
    bus1.rnd_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0; bus1.rnd_valid = 1'b0;
    tick(); tick();
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.xor0 !== 1'b1 || bus1.xor1 !== 1'b0 || bus1.stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL w1_result: out_valid=%b xor0=%b xor1=%b stall=%h, need 1 1 0 F",
               bus1.out_valid, bus1.xor0, bus1.xor1, bus1.stall_cnt);
    end
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.rnd_valid = 1'b0; bus8.out_ready = 1'b0;
    load8(8'h00, 8'h00, 8'h00, 8'h00, 24'h000000);
    bus1.in_valid = 1'b0; bus1.rnd_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.a0 = 1'b0; bus1.a1 = 1'b0; bus1.b0 = 1'b0; bus1.b1 = 1'b0; bus1.rnd = 3'b000;
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_async_reset();
    test_random();
    test_width1_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
